// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
//
// Arbitrates the processor's external memory port between two requesters:
// the serial command processor (port 0) and a second master (port 1). A granted
// request pauses the processor, waits PAUSE_SETTLE cycles, performs one WORD
// read or write on the external* lines and then pulses done for that port.
// A request accepted while finishing the previous one skips the settle phase
// because pause never drops between the two.
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : ties go to the port not granted last.
//                           undefined : fixed priority, port 0 wins ties.
//
// Parameters:
//   PAUSE_SETTLE  cycles between pause rising and the access (1..15)
//   READ_LATENCY  cycles from read mode to valid externalDataOut (1..7)
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   reqN_valid/write/address/data  request from port N (held until ready)
//   reqN_ready                     one-cycle accept pulse
//   reqN_done                      one-cycle completion pulse
//   reqN_rdata                     read data, held until port N's next read
//   pause                          stalls the processor
//   externalMemoryControl          external port owns memory (access cycles)
//   externalAddress/externalData   latched address and write data
//   externalReadMode/WriteMode     WORD during the access, NONE otherwise
//   externalDataOut                memory read data

module memory_port_arbiter #(
    parameter int unsigned PAUSE_SETTLE = 2,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_address,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_address,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,

    output logic        pause,
    output logic        externalMemoryControl,
    output logic [31:0] externalAddress,
    output logic [31:0] externalData,
    output logic [2:0]  externalReadMode,
    output logic [2:0]  externalWriteMode,
    input  logic [31:0] externalDataOut
);

    localparam logic [2:0] ReadWriteMode_NONE = 3'd0;
    localparam logic [2:0] ReadWriteMode_WORD = 3'd3;

    typedef enum logic [1:0] {StIdle, StSettle, StAccess, StDone} stateT;

    stateT       stateQ, stateD;
    logic [3:0]  settleCntQ, settleCntD;
    logic [2:0]  accessCntQ, accessCntD;
    logic        grantIdQ, grantIdD;
    logic        grantWriteQ, grantWriteD;
    logic [31:0] addrQ, addrD;
    logic [31:0] dataQ, dataD;
    logic [31:0] rdata0Q, rdata0D;
    logic [31:0] rdata1Q, rdata1D;

    logic anyValid;
    logic winner;
    logic accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic lastQ, lastD;
`endif

    // Requests are ignored while reset is held so ready cannot pulse during reset.
    assign anyValid = (req0_valid | req1_valid) & rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign winner = req0_valid ? (req1_valid ? ~lastQ : 1'b0) : 1'b1;
`else
    assign winner = ~req0_valid;
`endif

    always_comb begin
        stateD      = stateQ;
        settleCntD  = settleCntQ;
        accessCntD  = accessCntQ;
        grantIdD    = grantIdQ;
        grantWriteD = grantWriteQ;
        addrD       = addrQ;
        dataD       = dataQ;
        rdata0D     = rdata0Q;
        rdata1D     = rdata1Q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        lastD       = lastQ;
`endif
        accept                = 1'b0;
        pause                 = 1'b0;
        externalMemoryControl = 1'b0;
        externalReadMode      = ReadWriteMode_NONE;
        externalWriteMode     = ReadWriteMode_NONE;
        req0_ready            = 1'b0;
        req1_ready            = 1'b0;
        req0_done             = 1'b0;
        req1_done             = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (anyValid) begin
                    accept     = 1'b1;
                    stateD     = StSettle;
                    settleCntD = 4'(PAUSE_SETTLE);
                end
            end

            StSettle: begin
                pause      = 1'b1;
                settleCntD = settleCntQ - 4'd1;
                if (settleCntQ <= 4'd1) begin
                    stateD = StAccess;
                end
            end

            StAccess: begin
                pause                 = 1'b1;
                externalMemoryControl = 1'b1;
                if (grantWriteQ) begin
                    externalWriteMode = ReadWriteMode_WORD;
                    stateD            = StDone;
                end else begin
                    externalReadMode = ReadWriteMode_WORD;
                    // accessCnt counts down READ_LATENCY extra cycles; capture on the last.
                    if (accessCntQ == 3'd0) begin
                        if (grantIdQ) begin
                            rdata1D = externalDataOut;
                        end else begin
                            rdata0D = externalDataOut;
                        end
                        stateD = StDone;
                    end else begin
                        accessCntD = accessCntQ - 3'd1;
                    end
                end
            end

            StDone: begin
                pause     = 1'b1;
                req0_done = ~grantIdQ;
                req1_done = grantIdQ;
                if (anyValid) begin
                    accept = 1'b1;
                    stateD = StAccess;
                end else begin
                    stateD = StIdle;
                end
            end

            default: begin
                stateD = StIdle;
            end
        endcase

        if (accept) begin
            req0_ready  = ~winner;
            req1_ready  = winner;
            grantIdD    = winner;
            grantWriteD = winner ? req1_write : req0_write;
            addrD       = winner ? req1_address : req0_address;
            dataD       = winner ? req1_data : req0_data;
            accessCntD  = 3'(READ_LATENCY);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastD       = winner;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ      <= StIdle;
            settleCntQ  <= 4'd0;
            accessCntQ  <= 3'd0;
            grantIdQ    <= 1'b0;
            grantWriteQ <= 1'b0;
            addrQ       <= 32'd0;
            dataQ       <= 32'd0;
            rdata0Q     <= 32'd0;
            rdata1Q     <= 32'd0;
        end else begin
            stateQ      <= stateD;
            settleCntQ  <= settleCntD;
            accessCntQ  <= accessCntD;
            grantIdQ    <= grantIdD;
            grantWriteQ <= grantWriteD;
            addrQ       <= addrD;
            dataQ       <= dataD;
            rdata0Q     <= rdata0D;
            rdata1Q     <= rdata1D;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastQ <= 1'b1;
        end else begin
            lastQ <= lastD;
        end
    end
`endif

    assign externalAddress = addrQ;
    assign externalData    = dataQ;
    assign req0_rdata      = rdata0Q;
    assign req1_rdata      = rdata1Q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
`timescale 1ns / 1ps

module tb_memory_port_arbiter;

    localparam int PS = 2;
    localparam int RL = 1;
    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_WORD = 3'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_write, req0_ready, req0_done;
    logic [31:0] req0_address, req0_data, req0_rdata;
    logic        req1_valid, req1_write, req1_ready, req1_done;
    logic [31:0] req1_address, req1_data, req1_rdata;
    logic        pause, externalMemoryControl;
    logic [31:0] externalAddress, externalData, externalDataOut;
    logic [2:0]  externalReadMode, externalWriteMode;

    logic [31:0] memData;
    int          rdCnt;
    int          passCount = 0;
    int          checkCount = 0;

    always #5 clk = ~clk;

    // Memory model: data is only valid once read mode has been held RL cycles.
    always @(posedge clk) begin
        if (externalReadMode == MODE_WORD) rdCnt <= rdCnt + 1;
        else rdCnt <= 0;
    end
    assign externalDataOut = (externalReadMode == MODE_WORD && rdCnt >= RL) ? memData
                                                                             : 32'hBAD0BAD0;

    memory_port_arbiter #(
        .PAUSE_SETTLE(PS),
        .READ_LATENCY(RL)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .req0_valid           (req0_valid),
        .req0_write           (req0_write),
        .req0_address         (req0_address),
        .req0_data            (req0_data),
        .req0_ready           (req0_ready),
        .req0_done            (req0_done),
        .req0_rdata           (req0_rdata),
        .req1_valid           (req1_valid),
        .req1_write           (req1_write),
        .req1_address         (req1_address),
        .req1_data            (req1_data),
        .req1_ready           (req1_ready),
        .req1_done            (req1_done),
        .req1_rdata           (req1_rdata),
        .pause                (pause),
        .externalMemoryControl(externalMemoryControl),
        .externalAddress      (externalAddress),
        .externalData         (externalData),
        .externalReadMode     (externalReadMode),
        .externalWriteMode    (externalWriteMode),
        .externalDataOut      (externalDataOut)
    );

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 0; req0_write = 0; req0_address = 0; req0_data = 0;
        req1_valid = 0; req1_write = 0; req1_address = 0; req1_data = 0;
        memData = 32'h0;
        repeat (3) @(negedge clk);
        req0_valid = 1'b1;  // must not be accepted while reset is held
        #1;
        checkCount++;
        if ({pause, externalMemoryControl, req0_ready, req1_ready, req0_done, req1_done} !== 6'b0)
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {pause, externalMemoryControl, req0_ready, req1_ready, req0_done, req1_done});
        else passCount++;
        checkCount++;
        if ({externalReadMode, externalWriteMode} !== {MODE_NONE, MODE_NONE})
            $display("FAIL reset_modes: got %h/%h, expected 0/0", externalReadMode,
                     externalWriteMode);
        else passCount++;
        checkCount++;
        if ({externalAddress, externalData, req0_rdata, req1_rdata} !== 128'd0)
            $display("FAIL reset_data: got %h %h %h %h, expected all 0", externalAddress,
                     externalData, req0_rdata, req1_rdata);
        else passCount++;
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkCount++;
        if (pause !== 1'b0) $display("FAIL idle_pause: got %b, expected 0", pause);
        else passCount++;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        req0_valid = 1; req0_write = 1; req0_address = 32'h10; req0_data = 32'hDEADBEEF;
        #1;  // cycle T
        checkCount++;
        if ({req0_ready, req1_ready, pause} !== 3'b100)
            $display("FAIL wr_accept: got ready0/ready1/pause %b, expected 100",
                     {req0_ready, req1_ready, pause});
        else passCount++;
        @(negedge clk); req0_valid = 0; #1;  // T+1
        checkCount++;
        if ({pause, externalMemoryControl} !== 2'b10)
            $display("FAIL wr_settle: got pause/ctl %b, expected 10", {pause, externalMemoryControl});
        else passCount++;
        @(negedge clk); #1;  // T+2
        checkCount++;
        if (externalWriteMode !== MODE_NONE)
            $display("FAIL wr_early_mode: got %h, expected %h", externalWriteMode, MODE_NONE);
        else passCount++;
        @(negedge clk); #1;  // T+3
        checkCount++;
        if ({externalWriteMode, externalReadMode, externalMemoryControl} !=={MODE_WORD, MODE_NONE, 1'b1})
            $display("FAIL wr_access_mode: got wm %h rm %h ctl %b, expected %h %h 1",
                     externalWriteMode, externalReadMode, externalMemoryControl, MODE_WORD, MODE_NONE);
        else passCount++;
        checkCount++;
        if ({externalAddress, externalData} !== {32'h10, 32'hDEADBEEF})
            $display("FAIL wr_access_bus: got %h %h, expected 00000010 deadbeef",
                     externalAddress, externalData);
        else passCount++;
        @(negedge clk); #1;  // T+4
        checkCount++;
        if ({req0_done, req1_done, pause, externalMemoryControl} !== 4'b1010)
            $display("FAIL wr_done: got done0/done1/pause/ctl %b, expected 1010",
                     {req0_done, req1_done, pause, externalMemoryControl});
        else passCount++;
        checkCount++;
        if (externalWriteMode !== MODE_NONE)
            $display("FAIL wr_done_mode: got %h, expected %h", externalWriteMode, MODE_NONE);
        else passCount++;
        @(negedge clk); #1;  // T+5
        @(negedge clk); #1;  // T+6
        checkCount++;
        if ({pause, req0_done} !== 2'b00)
            $display("FAIL wr_pause_fall: got pause/done0 %b, expected 00", {pause, req0_done});
        else passCount++;
    endtask

    task automatic test_read();
        memData = 32'h12345678;
        @(negedge clk);
        req1_valid = 1; req1_write = 0; req1_address = 32'h20; req1_data = 32'h0;
        #1;  // T
        checkCount++;
        if ({req0_ready, req1_ready} !== 2'b01)
            $display("FAIL rd_accept: got ready0/ready1 %b, expected 01", {req0_ready, req1_ready});
        else passCount++;
        @(negedge clk); req1_valid = 0;  // T+1
        @(negedge clk);                  // T+2
        for (int k = 3; k <= 4; k++) begin
            @(negedge clk); #1;
            checkCount++;
            if ({externalReadMode, externalWriteMode, externalAddress} !== {MODE_WORD, MODE_NONE, 32'h20})
                $display("FAIL rd_access_T%0d: got rm %h wm %h addr %h, expected %h %h 00000020",
                         k, externalReadMode, externalWriteMode, externalAddress, MODE_WORD, MODE_NONE);
            else passCount++;
            checkCount++;
            if (req1_done !== 1'b0) $display("FAIL rd_early_done_T%0d: got 1, expected 0", k);
            else passCount++;
        end
        @(negedge clk); #1;  // T+5
        checkCount++;
        if ({req1_done, req0_done, externalReadMode} !== {2'b10, MODE_NONE})
            $display("FAIL rd_done: got done1/done0 %b rm %h, expected 10 %h",
                     {req1_done, req0_done}, externalReadMode, MODE_NONE);
        else passCount++;
        checkCount++;
        if (req1_rdata !== 32'h12345678)
            $display("FAIL rd_data: got %h, expected 12345678", req1_rdata);
        else passCount++;
        memData = 32'hFFFF0000;
        repeat (3) @(negedge clk);
        #1;
        checkCount++;
        if ({req1_rdata, req0_rdata} !== {32'h12345678, 32'h0})
            $display("FAIL rd_hold: got %h %h, expected 12345678 00000000", req1_rdata, req0_rdata);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        int grants[$];
        int gcyc[$];
        logic pauseHist[40];
        bit bothReady = 0;
        bit dropped = 0;
        int done0Cnt = 0;
        int done1Cnt = 0;
        int expOrder[4];
        int expDone0;
        int bad;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expOrder = '{0, 1, 0, 1};
        expDone0 = 2;
`else
        expOrder = '{0, 0, 0, 0};
        expDone0 = 4;
`endif
        @(negedge clk);
        req0_valid = 1; req0_write = 1; req0_address = 32'h100; req0_data = 32'hA0A0A0A0;
        req1_valid = 1; req1_write = 1; req1_address = 32'h200; req1_data = 32'hB1B1B1B1;
        for (int c = 0; c < 40; c++) begin
            if (grants.size() == 4 && !dropped) begin
                req0_valid = 0; req1_valid = 0; dropped = 1;
            end
            #1;
            pauseHist[c] = pause;
            if (req0_ready && req1_ready) bothReady = 1;
            if (req0_done) done0Cnt++;
            if (req1_done) done1Cnt++;
            if ((req0_ready || req1_ready) && grants.size() < 4) begin
                grants.push_back(req1_ready ? 1 : 0);
                gcyc.push_back(c);
            end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        checkCount++;
        if (grants.size() != 4) $display("FAIL b2b_grant_count: got %0d, expected 4", grants.size());
        else passCount++;
        checkCount++;
        if (bothReady) $display("FAIL b2b_both_ready: got 1, expected 0");
        else passCount++;
        checkCount++;
        if (done0Cnt != expDone0 || done1Cnt != 4 - expDone0)
            $display("FAIL b2b_done_count: got %0d/%0d, expected %0d/%0d", done0Cnt, done1Cnt,
                     expDone0, 4 - expDone0);
        else passCount++;
        if (grants.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkCount++;
                if (grants[i] != expOrder[i])
                    $display("FAIL b2b_order_%0d: got port %0d, expected %0d", i, grants[i],
                             expOrder[i]);
                else passCount++;
            end
            checkCount++;
            if (gcyc[2] - gcyc[1] != 2 || gcyc[3] - gcyc[2] != 2)
                $display("FAIL b2b_spacing: got %0d,%0d, expected 2,2", gcyc[2] - gcyc[1],
                         gcyc[3] - gcyc[2]);
            else passCount++;
            bad = 0;
            for (int c = gcyc[0] + 1; c <= gcyc[3] + 2; c++) if (pauseHist[c] !== 1'b1) bad++;
            checkCount++;
            if (bad != 0) $display("FAIL b2b_pause_high: got %0d low cycles, expected 0", bad);
            else passCount++;
            checkCount++;
            if (pauseHist[gcyc[3] + 3] !== 1'b0)
                $display("FAIL b2b_pause_fall: got %b, expected 0", pauseHist[gcyc[3] + 3]);
            else passCount++;
        end
    endtask

    task automatic test_reset_mid_access();
        bit sawDone = 0;
        memData = 32'hCAFEF00D;
        @(negedge clk);
        req0_valid = 1; req0_write = 0; req0_address = 32'h40;
        #1;  // T
        checkCount++;
        if (req0_ready !== 1'b1) $display("FAIL rst_accept: got %b, expected 1", req0_ready);
        else passCount++;
        @(negedge clk); req0_valid = 0;  // T+1
        @(negedge clk);                  // T+2
        @(negedge clk); #1;              // T+3, read ACCESS
        checkCount++;
        if (externalReadMode !== MODE_WORD)
            $display("FAIL rst_pre_access: got %h, expected %h", externalReadMode, MODE_WORD);
        else passCount++;
        rst = 1'b0;
        #1;
        checkCount++;
        if ({pause, externalMemoryControl, req0_done, req1_done, externalReadMode,
             externalWriteMode} !== {4'b0, MODE_NONE, MODE_NONE})
            $display("FAIL rst_outputs: got pause %b ctl %b done %b%b rm %h wm %h, expected all 0",
                     pause, externalMemoryControl, req0_done, req1_done, externalReadMode,
                     externalWriteMode);
        else passCount++;
        checkCount++;
        if ({externalAddress, externalData, req1_rdata} !== 96'd0)
            $display("FAIL rst_latches: got %h %h %h, expected all 0", externalAddress,
                     externalData, req1_rdata);
        else passCount++;
        repeat (2) begin
            @(negedge clk); #1;
            if (req0_done || req1_done) sawDone = 1;
        end
        rst = 1'b1;
        @(negedge clk); #1;
        if (req0_done || req1_done) sawDone = 1;
        @(negedge clk);
        req0_valid = 1; req0_write = 1; req0_address = 32'h44; req0_data = 32'h5555AAAA;
        #1;  // T'
        checkCount++;
        if (req0_ready !== 1'b1) $display("FAIL rst_new_accept: got %b, expected 1", req0_ready);
        else passCount++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req0_valid = 0;
            #1;
            if (k < 4 && req0_done) sawDone = 1;
        end
        checkCount++;
        if ({req0_done, externalData} !== {1'b1, 32'h5555AAAA})
            $display("FAIL rst_new_done: got done %b data %h, expected 1 5555aaaa", req0_done,
                     externalData);
        else passCount++;
        checkCount++;
        if (sawDone) $display("FAIL rst_no_done: got a stray done, expected none");
        else passCount++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_withdrawal();
        bit saw1 = 0;
        @(negedge clk);
        req0_valid = 1; req0_write = 1; req0_address = 32'h50; req0_data = 32'h01020304;
        #1;  // T
        checkCount++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL ew_accept: got %b, expected 10", {req0_ready, req1_ready});
        else passCount++;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req0_valid = 0;
                req1_valid = 1; req1_write = 1; req1_address = 32'h300; req1_data = 32'h77;
            end
            if (k == 2) req1_valid = 0;
            #1;
            if (req1_ready || req1_done) saw1 = 1;
            if (k == 4) begin
                checkCount++;
                if (req0_done !== 1'b1) $display("FAIL ew_done0: got %b, expected 1", req0_done);
                else passCount++;
            end
            if (k == 5) begin
                checkCount++;
                if (pause !== 1'b0) $display("FAIL ew_pause_fall: got %b, expected 0", pause);
                else passCount++;
            end
        end
        checkCount++;
        if (saw1) $display("FAIL ew_req1_granted: got a req1 ready/done, expected none");
        else passCount++;
    endtask

    initial begin
        rdCnt = 0;
        test_reset();
        test_single_write();
        test_read();
        test_back_to_back();
        test_reset_mid_access();
        test_early_withdrawal();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
